// File: rtl/layer_mac_sequencer_pkg.sv
// rtl/layer_mac_sequencer_pkg.sv - layer_pkg: states, default sizes and weight address helper
// Stride and run length depend on LAYER_SEQ_BIAS_EN (one extra bias word per neuron).
package layer_pkg;

    localparam int N_INPUTS_DEF  = 5;
    localparam int N_NEURONS_DEF = 5;
    localparam int W_W_DEF       = 10;
    localparam int ACC_W_DEF     = 24;
    localparam int ADDR_W_DEF    = 8;

`ifdef LAYER_SEQ_BIAS_EN
    localparam int unsigned STRIDE = N_INPUTS_DEF + 1;
`else
    localparam int unsigned STRIDE = N_INPUTS_DEF;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ACT,
        ST_DONE
    } layer_state_t;

    function automatic logic [ADDR_W_DEF-1:0] weight_addr(input int unsigned neuron,
                                                          input int unsigned idx);
        int unsigned a;
        a = neuron * STRIDE + idx;
        return a[ADDR_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/layer_mac_sequencer_if.sv
// rtl/layer_mac_sequencer_if.sv - control, result and weight-memory signals of the layer sequencer
// master = host/memory side, slave = sequencer side.
interface layer_mac_sequencer_if #(
    parameter int N_INPUTS  = layer_pkg::N_INPUTS_DEF,
    parameter int N_NEURONS = layer_pkg::N_NEURONS_DEF,
    parameter int W_W       = layer_pkg::W_W_DEF,
    parameter int ADDR_W    = layer_pkg::ADDR_W_DEF
);
    logic                  start;
    logic [N_INPUTS-1:0]   in_vec;
    logic                  busy;
    logic                  done;
    logic [N_NEURONS-1:0]  out_vec;
    logic                  w_rd_en;
    logic [ADDR_W-1:0]     w_addr;
    logic signed [W_W-1:0] w_data;

    modport master (
        output start, in_vec, w_data,
        input  busy, done, out_vec, w_rd_en, w_addr
    );

    modport slave (
        input  start, in_vec, w_data,
        output busy, done, out_vec, w_rd_en, w_addr
    );
endinterface

// File: rtl/layer_mac_sequencer_step_activation.sv
// rtl/layer_mac_sequencer_step_activation.sv - step_activation: 1 when the signed sum is strictly positive
module step_activation #(
    parameter int ACC_W = layer_pkg::ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic                    act
);
    assign act = !acc[ACC_W-1] && (acc != '0);
endmodule

// File: rtl/layer_mac_sequencer.sv
// rtl/layer_mac_sequencer.sv - one shared MAC swept over all neurons, weights from external sync memory
// LAYER_SEQ_BIAS_EN adds a per-neuron bias word at idx = N_INPUTS, always accumulated.
module layer_mac_sequencer
    import layer_pkg::*;
#(
    parameter int N_INPUTS  = N_INPUTS_DEF,
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int W_W       = W_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    layer_mac_sequencer_if.slave bus
);

`ifdef LAYER_SEQ_BIAS_EN
    localparam int RUN_LEN = N_INPUTS + 1;
`else
    localparam int RUN_LEN = N_INPUTS;
`endif
    localparam int IW = $clog2(RUN_LEN + 1);
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    layer_state_t            state_q, state_d;
    logic [NW-1:0]           neuron_q, neuron_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           rd_idx_q, rd_idx_d;
    logic                    rd_pend_q, rd_pend_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N_INPUTS-1:0]     in_lat_q, in_lat_d;
    logic [N_NEURONS-1:0]    out_vec_q, out_vec_d;
    logic [ADDR_W-1:0]       w_addr_q, w_addr_d;

    logic signed [ACC_W-1:0] w_ext;
    logic                    gate;
    logic                    act;

    assign w_ext = {{(ACC_W-W_W){bus.w_data[W_W-1]}}, bus.w_data};

    // rd_idx tracks which read the arriving w_data belongs to (one-cycle memory latency).
`ifdef LAYER_SEQ_BIAS_EN
    assign gate = (32'(rd_idx_q) == N_INPUTS) ? 1'b1 : in_lat_q[rd_idx_q];
`else
    assign gate = in_lat_q[rd_idx_q];
`endif

    step_activation #(.ACC_W(ACC_W)) u_step (
        .acc (acc_q),
        .act (act)
    );

    always_comb begin
        state_d   = state_q;
        neuron_d  = neuron_q;
        idx_d     = idx_q;
        rd_idx_d  = rd_idx_q;
        rd_pend_d = 1'b0;
        in_lat_d  = in_lat_q;
        out_vec_d = out_vec_q;
        w_addr_d  = w_addr_q;
        acc_d     = (rd_pend_q && gate) ? acc_q + w_ext : acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    in_lat_d  = bus.in_vec;
                    neuron_d  = '0;
                    idx_d     = '0;
                    acc_d     = '0;
                    out_vec_d = '0;
                    w_addr_d  = weight_addr(0, 0);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_pend_d = 1'b1;
                rd_idx_d  = idx_q;
                if (32'(idx_q) == RUN_LEN - 1) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    w_addr_d = weight_addr(32'(neuron_q), 32'(idx_q) + 1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_ACT;
            end
            ST_ACT: begin
                out_vec_d[neuron_q] = act;
                acc_d               = '0;
                if (32'(neuron_q) == N_NEURONS - 1) begin
                    state_d = ST_DONE;
                end else begin
                    neuron_d = neuron_q + 1'b1;
                    idx_d    = '0;
                    w_addr_d = weight_addr(32'(neuron_q) + 1, 0);
                    state_d  = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            neuron_q  <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            rd_pend_q <= 1'b0;
            acc_q     <= '0;
            in_lat_q  <= '0;
            out_vec_q <= '0;
            w_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            neuron_q  <= neuron_d;
            idx_q     <= idx_d;
            rd_idx_q  <= rd_idx_d;
            rd_pend_q <= rd_pend_d;
            acc_q     <= acc_d;
            in_lat_q  <= in_lat_d;
            out_vec_q <= out_vec_d;
            w_addr_q  <= w_addr_d;
        end
    end

    assign bus.w_rd_en = (state_q == ST_RUN);
    assign bus.w_addr  = w_addr_q;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_ACT);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.out_vec = out_vec_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb/tb_layer_mac_sequencer.sv - scoreboard bench for layer_mac_sequencer; honours LAYER_SEQ_BIAS_EN
module tb_layer_mac_sequencer;

    localparam int NI  = 5;
    localparam int NN  = 5;
    localparam int WW  = 10;
    localparam int AW  = 24;
    localparam int ADW = 8;
`ifdef LAYER_SEQ_BIAS_EN
    localparam int TB_STRIDE = NI + 1;
`else
    localparam int TB_STRIDE = NI;
`endif
    localparam int LAT = NN * (TB_STRIDE + 2) + 1;

    typedef struct {
        logic [NN-1:0] out;
        int            done_edge;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   mem [256];
    exp_t exp_q [$];
    int   addr_q [$];
    logic [NN-1:0] last_out = '0;

    layer_mac_sequencer_if #(.N_INPUTS(NI), .N_NEURONS(NN), .W_W(WW), .ADDR_W(ADW)) bus ();

    layer_mac_sequencer #(
        .N_INPUTS (NI),
        .N_NEURONS(NN),
        .W_W      (WW),
        .ACC_W    (AW),
        .ADDR_W   (ADW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    always @(posedge clk) if (bus.w_rd_en) bus.w_data <= WW'(mem[bus.w_addr]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        int   a;
        exp_t e;
        if (rst_n) begin
            if (bus.w_rd_en) begin
                check("rd_expected", 32'(addr_q.size() > 0), 1);
                if (addr_q.size() > 0) begin
                    a = addr_q.pop_front();
                    check("w_addr", 32'(bus.w_addr), a);
                end
            end
            if (bus.done) begin
                check("done_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last_out = e.out;
                    check("out_vec", 32'(bus.out_vec), 32'(e.out));
                    check("done_cycle", edge_n, e.done_edge);
                    check("busy_at_done", 32'(bus.busy), 0);
                end
            end
        end
    end

    // Reference: per-neuron dot product of the binary inputs with that neuron's weight block.
    task automatic push_expect(input logic [NI-1:0] v, input int acc_edge);
        exp_t e;
        e.out = '0;
        for (int n = 0; n < NN; n++) begin
            int sum = 0;
            for (int j = 0; j < TB_STRIDE; j++) begin
                addr_q.push_back(n * TB_STRIDE + j);
                if (j == NI || v[j]) sum += mem[n * TB_STRIDE + j];
            end
            e.out[n] = (sum > 0);
        end
        e.done_edge = acc_edge + LAT - 1;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [NI-1:0] v);
        @(negedge clk);
        bus.in_vec = v;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        push_expect(v, edge_n);
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 32'(bus.busy), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        check("layer_completed", 32'(exp_q.size()), 0);
        check("addr_drained", 32'(addr_q.size()), 0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        check("out_vec_held", 32'(bus.out_vec), 32'(last_out));
    endtask

    task automatic fill_mem(input int val);
        for (int i = 0; i < NN * TB_STRIDE; i++) mem[i] = val;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NN * TB_STRIDE; i++) mem[i] = int'($urandom_range(0, 1023)) - 512;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(bus.busy), 0);
        check({tag, "_done"},    32'(bus.done), 0);
        check({tag, "_w_rd_en"}, 32'(bus.w_rd_en), 0);
        check({tag, "_w_addr"},  32'(bus.w_addr), 0);
        check({tag, "_out_vec"}, 32'(bus.out_vec), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        logic [NI-1:0] v1, v2;
        bus.start  = 1'b0;
        bus.in_vec = '0;
        for (int i = 0; i < 256; i++) mem[i] = 0;

        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_w_rd_en", 32'(bus.w_rd_en), 0);
        check("idle_busy", 32'(bus.busy), 0);

        fill_mem(1);
        issue(5'b11111);
        wait_idle();

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("idle_reset");
        last_out = '0;
        @(negedge clk);
        rst_n = 1'b1;

        fill_mem(1);
        for (int j = 0; j < NI; j++) mem[2 * TB_STRIDE + j] = -512;
        issue(5'b11111);
        wait_idle();

        fill_mem(3);
        issue(5'b00000);
        wait_idle();

        fill_random();
        issue(5'($urandom));
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        fill_mem(1);
        issue(5'b11111);
        repeat (3 * (TB_STRIDE + 2) + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        exp_q.delete();
        addr_q.delete();
        last_out = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("post_reset_out_vec", 32'(bus.out_vec), 0);

        for (int n = 0; n < NN; n++)
            for (int j = 0; j < TB_STRIDE; j++)
                mem[n * TB_STRIDE + j] = (j == NI) ? 1 : 0;
        issue(5'b11111);
        wait_idle();

        for (int k = 0; k < 12; k++) begin
            fill_random();
            issue(5'($urandom));
            wait_idle();
        end

        fill_random();
        v1 = 5'($urandom);
        v2 = ~v1;
        @(negedge clk);
        bus.in_vec = v1;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        a = edge_n;
        push_expect(v1, a);
        push_expect(v2, a + LAT + 1);
        @(negedge clk);
        bus.in_vec = v2;
        while (edge_n < a + LAT + 1) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_mac_sequencer.md
# layer_mac_sequencer

Time-multiplexed controller for one fully connected neuron layer. It shares a single multiply-accumulate datapath (binary input × signed 10-bit weight, 24-bit signed sum, step activation) across `N_NEURONS` neurons in sequence. Weights are streamed from an external synchronous weight memory. It sits between the feature-extraction front end and the output/decision stage of the drowsiness detector. It replaces per-neuron parallel multipliers with one shared arithmetic path.

## Interface
- `N_INPUTS`, 5: inputs per neuron
- `N_NEURONS`, 5: neurons in the layer
- `W_W`, 10: signed weight width
- `ACC_W`, 24: signed accumulator width
- `ADDR_W`, 8: weight memory address width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request a layer evaluation; accepted only in IDLE
- `in_vec` in `N_INPUTS`: binary input vector; bit j is input j; latched on accept
- `w_rd_en` out 1: weight memory read strobe
- `w_addr` out `ADDR_W`: weight memory address
- `w_data` in `W_W`: signed weight, valid exactly 1 cycle after `w_rd_en`
- `busy` out 1: high from the cycle after accept until `done`
- `done` out 1: one-cycle pulse; `out_vec` valid from this cycle
- `out_vec` out `N_NEURONS`: bit i is the activation of neuron i

## Operation
- States: IDLE, RUN, DRAIN, ACT, DONE.
- **IDLE, on `start`:**
  - Latch `in_vec`.
  - Set neuron=0, idx=0, acc=0.
  - Clear `out_vec`.
  - Go to RUN.
- **RUN:**
  - Assert `w_rd_en`, with `w_addr` = neuron*STRIDE + idx, where STRIDE = `N_INPUTS` (see Configuration).
  - Increment idx.
  - Leave for DRAIN after the last address.
- **Accumulate:** in every cycle after a read, acc += (in_bit[idx-1] ? sign-extend(`w_data`) : 0). This one-cycle pipeline overlaps RUN and DRAIN.
- **DRAIN:** no read; absorb the final `w_data`.
- **ACT:**
  - `out_vec[neuron]` = (acc > 0).
  - acc = 0 gives 0; negative acc gives 0.
  - If neuron = `N_NEURONS`-1, go to DONE. Otherwise increment neuron, reset idx and acc, and go to RUN.
- **DONE:** pulse `done`, deassert `busy`, return to IDLE.
- **`start` handling:**
  - Ignored outside IDLE, including in the DONE cycle.
  - `start` held high re-triggers on the first IDLE cycle.
- **Arithmetic:**
  - Full precision; no saturation.
  - `ACC_W`=24 cannot overflow for `N_INPUTS` ≤ 2^14.
  - `w_data` sign-extended to `ACC_W`.
- **`out_vec` retention:** holds until the next accepted `start`.
- **Reset:** asserting `rst_n` at any time, including mid-layer, immediately forces:
  - IDLE
  - `out_vec`=0, `busy`=0, `done`=0, `w_rd_en`=0, `w_addr`=0
  - acc=0, counters=0

## Timing
- Reset values: all outputs 0.
- Start accepted at edge T0: RUN begins at T0, and the first `w_rd_en` is seen in the cycle after T0.
- Per neuron: `N_INPUTS` RUN cycles + 1 DRAIN + 1 ACT = `N_INPUTS`+2 cycles.
- `done` is high `N_NEURONS`*(`N_INPUTS`+2)+1 cycles after the accept edge; 36 cycles at defaults.
- `w_addr` is registered and stable for the whole `w_rd_en` cycle. The memory must return data on the next edge, with no stall support.
- Minimum start-to-start interval: latency + 1 cycle.

## Configuration
- **`LAYER_SEQ_BIAS_EN` defined:**
  - Each neuron has one extra weight word, its bias, at idx = `N_INPUTS`, and STRIDE = `N_INPUTS`+1.
  - The bias is added unconditionally, independent of inputs.
  - RUN lasts `N_INPUTS`+1 cycles, so latency = `N_NEURONS`*(`N_INPUTS`+3)+1.
- **Undefined:** no bias; STRIDE = `N_INPUTS`; latency as in Timing.

## Structure
- Package `layer_pkg`:
  - State enum `layer_state_t`.
  - Default parameter constants.
  - Stride constant selected by `LAYER_SEQ_BIAS_EN`.
  - Function `weight_addr(neuron, idx)`.
- Sub-module `step_activation`: combinational, `ACC_W`-bit signed in, 1 bit out (> 0). It is instantiated once and shared by all neurons.
- The accumulator, counters and FSM live in the top; there is no RAM inside the block.

## Test plan
1. **Reset:** `rst_n`=0 mid-idle → all outputs 0. Release, with no `start` → stays idle, `w_rd_en`=0.
2. **All positive:** all weights +1, `in_vec`=5'b11111 → each acc=5, `out_vec`=5'b11111. `done` arrives exactly 36 cycles after accept, and addresses 0..24 appear in order.
3. **One negative neuron:** neuron 2 weights = -512, others +1, `in_vec`=5'b11111 → neuron 2 acc=-2560, `out_vec`=5'b11011.
4. **Input gating and zero boundary:** weights +3, `in_vec`=5'b00000 → every acc=0, `out_vec`=5'b00000, `done` still at 36.
5. **Start ignored, then mid-run reset:**
   - Pulse `start` during neuron 1 → ignored, latency unchanged.
   - Assert `rst_n`=0 during neuron 3 → `busy`, `out_vec` and `w_rd_en` go to 0 immediately, with no `done`.
6. **Bias build (`LAYER_SEQ_BIAS_EN`):** weights 0, biases +1 → `out_vec`=5'b11111, `done` at 41, bias addresses 5,11,17,23,29. Same weights in the default build → 5'b00000.
